// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Good bytes land in a show-ahead FIFO that the CPU drains with rd.
// Stop-bit errors and bytes lost to a full FIFO raise sticky flags, which
// clr_err clears.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk_xtal,
  input  logic        rst,
  input  logic [15:0] div16,
  input  logic        rx,
  input  logic        rd,
  input  logic        clr_err,
  output logic [7:0]  DataIn,
  output logic        rx_valid,
  output logic        rx_full,
  output logic        frame_err,
  output logic        overrun
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          sync1_reg;
  logic          rx_s_reg;
  logic          rx_s_d_reg;
  logic [15:0]   pre_reg;
  state_t        state_reg;
  logic [3:0]    tcnt_reg;
  logic [2:0]    bcnt_reg;
  logic [7:0]    shift_reg;
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [7:0]    mem_reg [DEPTH];
  logic          frame_err_reg;
  logic          overrun_reg;

  logic          tick;
  logic          start_edge;
  logic          stop_tick;
  logic          push;
  logic          bad_stop;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          drop;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  // Reset to idle-high so that reset release is never seen as a start edge.
  always_ff @(posedge clk_xtal) begin
    if (rst) begin
      sync1_reg  <= 1'b1;
      rx_s_reg   <= 1'b1;
      rx_s_d_reg <= 1'b1;
    end else begin
      sync1_reg  <= rx;
      rx_s_reg   <= sync1_reg;
      rx_s_d_reg <= rx_s_reg;
    end
  end

  // Only a real high-to-low transition starts a frame; a line held low never retriggers.
  assign start_edge = (state_reg == IDLE) && rx_s_d_reg && !rx_s_reg;
  assign tick       = (pre_reg == div16);

  // Oversample prescaler, phase-aligned to the start edge.
  always_ff @(posedge clk_xtal) begin
    if (rst || start_edge) begin
      pre_reg <= 16'd0;
    end else if (tick) begin
      pre_reg <= 16'd0;
    end else begin
      pre_reg <= pre_reg + 16'd1;
    end
  end

  // Frame FSM: check the start bit at its middle, then take every 16th tick from there.
  always_ff @(posedge clk_xtal) begin
    if (rst) begin
      state_reg <= IDLE;
      tcnt_reg  <= 4'd0;
      bcnt_reg  <= 3'd0;
      shift_reg <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            tcnt_reg  <= 4'd0;
            state_reg <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tcnt_reg == 4'd7) begin
              if (!rx_s_reg) begin
                tcnt_reg  <= 4'd0;
                bcnt_reg  <= 3'd0;
                state_reg <= DATA;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              tcnt_reg <= tcnt_reg + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tcnt_reg <= tcnt_reg + 4'd1;
            if (tcnt_reg == 4'd15) begin
              shift_reg <= {rx_s_reg, shift_reg[7:1]};
              bcnt_reg  <= bcnt_reg + 3'd1;
              if (bcnt_reg == 3'd7) begin
                state_reg <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            tcnt_reg <= tcnt_reg + 4'd1;
            if (tcnt_reg == 4'd15) begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stop_tick = (state_reg == STOP) && tick && (tcnt_reg == 4'd15);
  assign push      = stop_tick && rx_s_reg;
  assign bad_stop  = stop_tick && !rx_s_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = rd && !empty;
  // A same-cycle pop makes room, so a push into a full FIFO still succeeds.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // FIFO storage; no reset needed since the output is gated by empty.
  always_ff @(posedge clk_xtal) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg[AW-1:0]] <= shift_reg;
    end
  end

  // FIFO pointers with one extra wrap bit to tell full from empty.
  always_ff @(posedge clk_xtal) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Sticky error flags; a set condition beats a same-cycle clear.
  always_ff @(posedge clk_xtal) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (clr_err) begin
        frame_err_reg <= 1'b0;
        overrun_reg   <= 1'b0;
      end
      if (bad_stop) begin
        frame_err_reg <= 1'b1;
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign DataIn    = empty ? 8'h00 : mem_reg[rd_ptr_reg[AW-1:0]];
  assign rx_valid  = !empty;
  assign rx_full   = full;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo at div16=3 (64 clocks per bit).
module tb_uart_rx_fifo;

  localparam int BIT = 64;

  logic        clk;
  logic        rst;
  logic [15:0] div16;
  logic        rx;
  logic        rd;
  logic        clr_err;
  logic [7:0]  DataIn;
  logic        rx_valid;
  logic        rx_full;
  logic        frame_err;
  logic        overrun;

  int passed;
  int total;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk_xtal (clk),
    .rst      (rst),
    .div16    (div16),
    .rx       (rx),
    .rd       (rd),
    .clr_err  (clr_err),
    .DataIn   (DataIn),
    .rx_valid (rx_valid),
    .rx_full  (rx_full),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one frame starting now; must be called right after a negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else passed++;
    total++; if (DataIn !== 8'h00) $display("FAIL reset_data: got %h want 00", DataIn); else passed++;
    total++; if (rx_full !== 1'b0) $display("FAIL reset_rx_full: got %b want 0", rx_full); else passed++;
    total++; if ({frame_err, overrun} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {frame_err, overrun}); else passed++;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single();
    int cyc;
    cyc = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (!rx_valid && cyc < 700) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    // Stop-bit middle is 9.5 bits = 608 clocks after the start edge, plus sync delay.
    total++; if (cyc < 606 || cyc > 616) $display("FAIL single_latency: got %0d cycles want 606..616", cyc); else passed++;
    total++; if (rx_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rx_valid); else passed++;
    total++; if (DataIn !== 8'hA5) $display("FAIL single_data: got %h want a5", DataIn); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL single_frame_err: got %b want 0", frame_err); else passed++;
    pulse_rd();
    total++; if (rx_valid !== 1'b0) $display("FAIL single_pop_valid: got %b want 0", rx_valid); else passed++;
    total++; if (DataIn !== 8'h00) $display("FAIL single_pop_data: got %h want 00", DataIn); else passed++;
    $display("test_single: A5 received in %0d cycles", cyc);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp3 [3];
    exp3 = '{8'h00, 8'hFF, 8'h3C};
    for (int i = 0; i < 3; i++) send_byte(exp3[i], 1'b1);
    total++; if ({frame_err, overrun} !== 2'b00) $display("FAIL b2b_flags: got %b want 00", {frame_err, overrun}); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid_%0d: got %b want 1", i, rx_valid); else passed++;
      total++; if (DataIn !== exp3[i]) $display("FAIL b2b_data_%0d: got %h want %h", i, DataIn, exp3[i]); else passed++;
      pulse_rd();
    end
    total++; if (rx_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", rx_valid); else passed++;
    $display("test_back_to_back done");
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    total++; if (rx_valid !== 1'b0) $display("FAIL glitch_valid: got %b want 0", rx_valid); else passed++;
    total++; if ({frame_err, overrun} !== 2'b00) $display("FAIL glitch_flags: got %b want 00", {frame_err, overrun}); else passed++;
    send_byte(8'h55, 1'b1);
    total++; if (DataIn !== 8'h55) $display("FAIL glitch_next_data: got %h want 55", DataIn); else passed++;
    pulse_rd();
    $display("test_glitch done");
  endtask

  task automatic test_frame_err();
    send_byte(8'h81, 1'b0);
    repeat (20) @(negedge clk);
    total++; if (frame_err !== 1'b1) $display("FAIL ferr_set: got %b want 1", frame_err); else passed++;
    total++; if (rx_valid !== 1'b0) $display("FAIL ferr_no_push: got %b want 0", rx_valid); else passed++;
    pulse_clr();
    total++; if (frame_err !== 1'b0) $display("FAIL ferr_clear: got %b want 0", frame_err); else passed++;
    $display("test_frame_err done");
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    for (int i = 1; i <= 17; i++) send_byte(8'(i), 1'b1);
    total++; if (rx_full !== 1'b1) $display("FAIL ovr_full: got %b want 1", rx_full); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
    for (int i = 1; i <= 16; i++) begin
      e = 8'(i);
      total++; if (DataIn !== e) $display("FAIL ovr_read_%0d: got %h want %h", i, DataIn, e); else passed++;
      pulse_rd();
    end
    total++; if (rx_valid !== 1'b0) $display("FAIL ovr_drained: got %b want 0", rx_valid); else passed++;
    pulse_clr();
    $display("test_overrun done");
  endtask

  task automatic test_overrun_pop();
    logic [7:0] e;
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b1);
    // The 17th byte is pushed on the 611th rising edge after its start bit is driven.
    fork
      send_byte(8'h11, 1'b1);
      begin
        repeat (610) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    total++; if (overrun !== 1'b0) $display("FAIL ovrpop_flag: got %b want 0", overrun); else passed++;
    total++; if (rx_full !== 1'b1) $display("FAIL ovrpop_full: got %b want 1", rx_full); else passed++;
    for (int i = 2; i <= 17; i++) begin
      e = 8'(i);
      total++; if (DataIn !== e) $display("FAIL ovrpop_read_%0d: got %h want %h", i, DataIn, e); else passed++;
      pulse_rd();
    end
    $display("test_overrun_pop done");
  endtask

  task automatic test_mid_reset();
    send_byte(8'h99, 1'b1);
    send_byte(8'h40, 1'b0);
    repeat (10) @(negedge clk);
    total++; if ({rx_valid, frame_err} !== 2'b11) $display("FAIL mrst_pre: got %b want 11", {rx_valid, frame_err}); else passed++;
    // Start of 8'h77, then cut it off with reset during the data bits.
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (rx_valid !== 1'b0) $display("FAIL mrst_valid: got %b want 0", rx_valid); else passed++;
    total++; if (DataIn !== 8'h00) $display("FAIL mrst_data: got %h want 00", DataIn); else passed++;
    total++; if ({rx_full, frame_err, overrun} !== 3'b000) $display("FAIL mrst_flags: got %b want 000", {rx_full, frame_err, overrun}); else passed++;
    repeat (700) @(negedge clk);
    total++; if (rx_valid !== 1'b0) $display("FAIL mrst_nothing: got %b want 0", rx_valid); else passed++;
    send_byte(8'h12, 1'b1);
    total++; if (DataIn !== 8'h12) $display("FAIL mrst_next: got %h want 12", DataIn); else passed++;
    pulse_rd();
    $display("test_mid_reset done");
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    rst     = 1'b1;
    div16   = 16'd3;
    rx      = 1'b1;
    rd      = 1'b0;
    clr_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_overrun_pop();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Standalone UART receiver with 16x oversampling, mid-bit sampling, framing and overrun detection, and a show-ahead receive FIFO. It is the receiving end of the CPU's 8N1 serial link. It replaces single-sample-per-bit reception with a robust front end that the CPU drains through a read strobe. It sits between the external rx pin and the CPU I/O register bank.

## Interface
- DEPTH, 16, FIFO entries; power of two, minimum 2
- clk_xtal  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous reset, active-high
- div16  input  16  clk_xtal cycles per oversample tick minus 1; static while receiving
- rx  input  1  asynchronous serial line; idles high
- rd  input  1  pop strobe; one entry per cycle while high and rx_valid=1
- clr_err  input  1  clears frame_err and overrun
- DataIn  output  8  FIFO head byte; 8'h00 when empty
- rx_valid  output  1  FIFO not empty
- rx_full  output  1  FIFO holds DEPTH entries
- frame_err  output  1  sticky; stop bit sampled low
- overrun  output  1  sticky; good byte arrived while FIFO full and not popped

## Operation
- Synchronizer: rx passes through two flops to give rx_s. rx_s_d is the previous value of rx_s.
- Prescaler: a 16-bit counter counts 0..div16. tick is high for one cycle when the counter equals div16, and the counter then wraps to 0.
- The prescaler is forced to 0 on the cycle a start edge is detected, so sampling is phase-aligned to the edge.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). One bit lasts 16 ticks.
- FSM states are IDLE, START, DATA, STOP. A 4-bit tick counter (tcnt) and a 3-bit bit counter (bcnt) drive the transitions.
- IDLE: a falling edge (rx_s_d=1, rx_s=0) sets tcnt=0 and moves to START.
  - A line held low, such as a break or a line stuck after a framing error, does not retrigger. A new high-to-low edge is required.
- START: on the tick where tcnt=7 (mid-bit), sample rx_s.
  - rx_s=0: clear tcnt and bcnt, go to DATA.
  - rx_s=1: false start, return to IDLE with no flags set.
- DATA: on each tick where tcnt=15, shift rx_s into shift[7] (right shift), then increment bcnt.
  - After the 8th sample (bcnt wraps 7 to 0), go to STOP.
  - All samples fall at mid-bit, because the count starts from the START mid-point.
- STOP: on the tick where tcnt=15, sample rx_s, then go to IDLE.
  - rx_s=1: push shift into the FIFO.
  - rx_s=0: discard the byte and set frame_err.
- FIFO: DEPTH x 8 memory with log2(DEPTH)+1-bit read and write pointers. Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal.
- Push when full without a same-cycle pop: drop the byte and set overrun.
- Push and pop in the same cycle:
  - When full: both are performed, the count is unchanged, and overrun is not set.
  - When empty: the pop is ignored and the push is performed.
- rd while empty has no effect.
- Sticky flags: clr_err clears them. If a set condition and clr_err occur in the same cycle, the flag ends set.
- Reset: state IDLE; prescaler, tcnt, bcnt, shift and pointers 0; frame_err=0, overrun=0, rx_valid=0, rx_full=0, DataIn=8'h00. The synchronizer flops are reset to 1.
- Reset mid-frame abandons the frame and leaves nothing in the FIFO.

## Timing
- Bit period is 16*(div16+1) clk_xtal cycles.
- From the rx falling edge to the START decision takes 2 cycles of synchronizer delay plus 8*(div16+1) cycles, give or take one tick.
- rx_valid, rx_full and DataIn update on the cycle after the STOP-sample tick.
- Read handshake: DataIn is valid whenever rx_valid=1. With rd high on a rising edge, the next head appears on the following cycle.
- Back-to-back frames: the STOP state exits at stop mid-bit, so a start edge arriving half a bit later is caught.
- Tolerated baud mismatch is about ±4% per frame.

## Test plan
- div16=3, send 8'hA5 as a correct frame -> rx_valid rises within 2 cycles after stop mid-bit, DataIn=8'hA5, frame_err=0. rd for one cycle -> rx_valid=0, DataIn=8'h00.
- Send 8'h00, 8'hFF, 8'h3C back-to-back with no idle time, rd held low -> three entries read in order, no errors.
- Low glitch of 4*(div16+1) cycles on rx -> FIFO unchanged, no flags, FSM back in IDLE. Then a valid 8'h55 is received correctly.
- Send 8'h81 with the stop bit forced to 0 -> nothing pushed, frame_err=1. clr_err pulse -> frame_err=0.
- DEPTH=16: send 17 bytes (0x01..0x11) without reads -> rx_full=1, overrun=1, and reads return 0x01..0x10.
  - Repeat with a rd pulse on the 17th push cycle -> overrun=0, and 0x11 is retained as the last entry.
- Assert rst for 1 cycle mid-DATA of 8'h77 -> all outputs at reset values. The next full frame 8'h12 is received correctly.
